// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared stage-state enum, control bit positions and EX/MEM payload layout.
package cpu_pipe_pkg;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} stage_state_e;
  localparam int M_READ = 0;
  localparam int M_WRITE = 1;
  localparam int WB_REGWRITE = 0;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF = 5;
  localparam int WB_W_DEF = 2;
  typedef struct packed {
    logic [WB_W_DEF-1:0]   wb;
    logic [1:0]            m;
    logic [DATA_W_DEF-1:0] alu;
    logic [DATA_W_DEF-1:0] wdata;
    logic [REG_W_DEF-1:0]  rd;
  } ex_mem_payload_t;
endpackage

// File: rtl/pipe_skid_slice.sv
// pipe_skid_slice: generic valid/ready register slice with optional 2-entry skid buffer.
module pipe_skid_slice
  import cpu_pipe_pkg::*;
#(
  parameter int W = 8,
  parameter bit SKID = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);
  stage_state_e state_q, state_d;
  logic [W-1:0] out_q, out_d, skid_q, skid_d;
  logic acc, ret;
  assign valid_o = state_q != EMPTY;
  // Without a skid entry, BUSY can only accept when it also retires, so FULL is never reached.
  assign ready_o = SKID ? (state_q != FULL) : (ready_i | !valid_o);
  assign acc = valid_i & ready_o;
  assign ret = valid_o & ready_i;
  assign data_o = out_q;
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    skid_d = skid_q;
    if (flush_i) state_d = EMPTY;
    else begin
      unique case (state_q)
        EMPTY: if (acc) begin
          out_d = data_i;
          state_d = BUSY;
        end
        BUSY: if (acc && ret) out_d = data_i;
          else if (acc) begin
            skid_d = data_i;
            state_d = FULL;
          end else if (ret) state_d = EMPTY;
        FULL: if (ret) begin
          out_d = skid_q;
          state_d = BUSY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      skid_q <= skid_d;
    end
  end
endmodule

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX->MEM stage register with handshake, flush and valid-gated controls.
module ex_mem_pipe_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W = 5,
  parameter int WB_W = 2,
  parameter bit SKID = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [1:0]        M_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic [DATA_W-1:0] mux7_i,
  input  logic [REG_W-1:0]  mux3_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [DATA_W-1:0] Address_o,
  output logic [DATA_W-1:0] Write_data_o,
  output logic [REG_W-1:0]  mux3_result_o
);
  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [1:0]        m;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  rd;
  } payload_t;
  payload_t in_p, out_p;
  assign in_p = '{wb: WB_i, m: M_i, alu: ALUResult_i, wdata: mux7_i, rd: mux3_i};
  pipe_skid_slice #(.W($bits(payload_t)), .SKID(SKID)) u_slice (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(in_p),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(out_p)
  );
  assign MemRead_o = valid_o & out_p.m[M_READ];
  assign MemWrite_o = valid_o & out_p.m[M_WRITE];
  assign Address_o = out_p.alu;
  assign Write_data_o = out_p.wdata;
  assign mux3_result_o = out_p.rd;
  always_comb begin
    WB_o = out_p.wb;
    WB_o[WB_REGWRITE] = out_p.wb[WB_REGWRITE] & valid_o;
  end
  // A stalled producer must keep its offered instruction stable until it is taken.
  a_stable_offer: assert property (@(posedge clk_i) disable iff (!rst_i)
    (valid_i && !ready_o && !flush_i) |=> (!valid_i || $stable(in_p)));
endmodule
